timer_sched: RTL and testbench

Multi-channel timeout scheduler that shares one free-running tick counter among `NCH` requesters. Each requester arms a one-shot deadline through a round-robin arbitrated request/grant handshake. The block tracks every armed deadline, signals expiry per channel and raises a combined interrupt. It sits beside the APB4 timer and is clocked by the APB clock. Its `tick_i` is driven by the prescaled timer clock, re-synchronised to a single-cycle pulse.

---
 rtl/timer_sched.sv | 161 ++++++++++++++++
 tb/tb_timer_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: multi-channel one-shot deadline scheduler sharing one free-running
// tick counter. Channels arm through a round-robin request/grant handshake; the
// expiry test is wrap-safe (MSB of now - deadline).
// Optional macro TIMER_SCHED_PERIODIC_EN adds periodic_i and per-channel period
// registers for automatic re-arm on expiry.
module timer_sched #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     tick_i,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH*CNT_WIDTH-1:0] delay_i,
  output logic [NCH-1:0]           grant_o,
  input  logic [NCH-1:0]           cancel_i,
  input  logic [NCH-1:0]           ack_i,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic [NCH-1:0]           periodic_i,
`endif
  output logic [NCH-1:0]           busy_o,
  output logic [NCH-1:0]           expire_o,
  output logic [NCH-1:0]           pend_o,
  output logic                     irq_o,
  output logic [CNT_WIDTH-1:0]     now_o
);

  localparam int unsigned PtrW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IdxW = PtrW + 1;
  localparam logic [IdxW-1:0] NchIdx = IdxW'(NCH);
  localparam logic [PtrW-1:0] LastCh = PtrW'(NCH - 1);
  localparam logic [CNT_WIDTH-1:0] DlyMin = CNT_WIDTH'(1);
  // Largest delay that still keeps the MSB-of-difference test unambiguous.
  localparam logic [CNT_WIDTH-1:0] DlyMax = {1'b0, {(CNT_WIDTH-1){1'b1}}};

  logic [CNT_WIDTH-1:0] r_now;
  logic [PtrW-1:0]      r_ptr;
  logic [NCH-1:0]       r_busy;
  logic [NCH-1:0]       r_pend;
  logic [NCH-1:0]       r_expire;
  logic                 r_irq;
  logic [CNT_WIDTH-1:0] r_deadline [NCH];
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [CNT_WIDTH-1:0] r_period [NCH];
`endif

  logic [NCH-1:0]       w_cand;
  logic [NCH-1:0]       w_grant;
  logic                 w_found;
  logic [IdxW-1:0]      w_idx;
  logic [PtrW-1:0]      w_gidx;
  logic [PtrW-1:0]      w_ptr_d;
  logic [NCH-1:0]       w_due;
  logic [NCH-1:0]       w_fire;
  logic [NCH-1:0]       w_busy_d;
  logic [NCH-1:0]       w_pend_d;
  logic [CNT_WIDTH-1:0] w_dly        [NCH];
  logic [CNT_WIDTH-1:0] w_clamp      [NCH];
  logic [CNT_WIDTH-1:0] w_diff       [NCH];
  logic [CNT_WIDTH-1:0] w_deadline_d [NCH];

  // Round-robin arbiter: first candidate at or after the pointer wins.
  always_comb begin
    w_cand  = req_i & ~cancel_i;
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_gidx  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_idx = {1'b0, r_ptr} + IdxW'(i);
      if (w_idx >= NchIdx) w_idx = w_idx - NchIdx;
      if (!w_found && w_cand[w_idx[PtrW-1:0]]) begin
        w_found                  = 1'b1;
        w_grant[w_idx[PtrW-1:0]] = 1'b1;
        w_gidx                   = w_idx[PtrW-1:0];
      end
    end
    w_ptr_d = (w_gidx == LastCh) ? '0 : w_gidx + PtrW'(1);
  end

  // Per-channel delay clamp and wrap-safe due detection.
  always_comb begin
    w_dly   = '{default: '0};
    w_clamp = '{default: '0};
    w_diff  = '{default: '0};
    w_due   = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      w_dly[k] = delay_i[k*CNT_WIDTH +: CNT_WIDTH];
      if (w_dly[k] == '0)                w_clamp[k] = DlyMin;
      else if (w_dly[k][CNT_WIDTH-1])    w_clamp[k] = DlyMax;
      else                               w_clamp[k] = w_dly[k];
      w_diff[k] = r_now - r_deadline[k];
      w_due[k]  = r_busy[k] & ~w_diff[k][CNT_WIDTH-1];
    end
  end

  // Next-state: cancel beats grant beats expiry; expiry set beats ack.
  always_comb begin
    w_fire       = w_due & ~cancel_i & ~w_grant;
    w_pend_d     = (r_pend & ~ack_i) | w_fire;
    w_busy_d     = r_busy;
    w_deadline_d = r_deadline;
    for (int k = 0; k < int'(NCH); k++) begin
      if (cancel_i[k]) begin
        w_busy_d[k] = 1'b0;
      end else if (w_grant[k]) begin
        w_busy_d[k]     = 1'b1;
        w_deadline_d[k] = r_now + w_clamp[k];
      end else if (w_fire[k]) begin
`ifdef TIMER_SCHED_PERIODIC_EN
        if (periodic_i[k]) w_deadline_d[k] = r_deadline[k] + r_period[k];
        else               w_busy_d[k]     = 1'b0;
`else
        w_busy_d[k] = 1'b0;
`endif
      end
    end
  end

  // Counter, arbiter pointer, channel state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_now    <= '0;
      r_ptr    <= '0;
      r_busy   <= '0;
      r_pend   <= '0;
      r_expire <= '0;
      r_irq    <= 1'b0;
      for (int k = 0; k < int'(NCH); k++) r_deadline[k] <= '0;
    end else begin
      if (tick_i)  r_now <= r_now + CNT_WIDTH'(1);
      if (w_found) r_ptr <= w_ptr_d;
      r_busy     <= w_busy_d;
      r_pend     <= w_pend_d;
      r_expire   <= w_fire;
      r_irq      <= |w_pend_d;
      r_deadline <= w_deadline_d;
    end
  end

`ifdef TIMER_SCHED_PERIODIC_EN
  // Period register holds the clamped delay captured at grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < int'(NCH); k++) r_period[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (w_grant[k]) r_period[k] <= w_clamp[k];
      end
    end
  end
`endif

  assign grant_o  = w_grant;
  assign busy_o   = r_busy;
  assign expire_o = r_expire;
  assign pend_o   = r_pend;
  assign irq_o    = r_irq;
  assign now_o    = r_now;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with NCH=4 and an 8-bit counter so the wrap
// cases are reachable in a few hundred cycles.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [3:0]  req, cancel, ack;
  logic [31:0] delay;
  logic [3:0]  grant, busy, expire, pend;
  logic        irq;
  logic [7:0]  now;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [3:0]  periodic;
`endif

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_now;

  always #5 clk = ~clk;

  timer_sched #(.NCH(4), .CNT_WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .tick_i    (tick),
    .req_i     (req),
    .delay_i   (delay),
    .grant_o   (grant),
    .cancel_i  (cancel),
    .ack_i     (ack),
`ifdef TIMER_SCHED_PERIODIC_EN
    .periodic_i(periodic),
`endif
    .busy_o    (busy),
    .expire_o  (expire),
    .pend_o    (pend),
    .irq_o     (irq),
    .now_o     (now)
  );

  // Advance one clock; the bench tracks the expected count itself.
  task automatic step();
    @(posedge clk);
    if (!rst_n)    exp_now = 8'd0;
    else if (tick) exp_now = exp_now + 8'd1;
    #1;
  endtask

  task automatic set_dly(input int ch, input logic [7:0] v);
    delay[ch*8 +: 8] = v;
  endtask

  task automatic advance_to(input logic [7:0] target);
    while (exp_now != target) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b1; req = '0; cancel = '0; ack = '0; delay = '0;
    exp_now = 8'd0;
    step(); step();
    checks++; if (now !== 8'd0) $display("FAIL reset_now: got %0d want 0", now); else passed++;
    checks++; if ({busy, pend, expire, grant, irq} !== 17'd0)
      $display("FAIL reset_outputs: got %b want 0", {busy, pend, expire, grant, irq});
    else passed++;
    rst_n = 1'b1;
    tick  = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] tg [7];
    logic [3:0] tb [7];
    logic [3:0] te [7];
    tg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    tb = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    te = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    tick = 1'b1; req = 4'b1111; delay = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req = 4'b0000;
      #1;
      checks++; if (grant !== tg[c]) $display("FAIL rr_grant c=%0d: got %b want %b", c, grant, tg[c]); else passed++;
      checks++; if (busy !== tb[c]) $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, tb[c]); else passed++;
      checks++; if (expire !== te[c]) $display("FAIL rr_expire c=%0d: got %b want %b", c, expire, te[c]); else passed++;
      step();
    end
    checks++; if ({pend, irq} !== 5'b11111) $display("FAIL rr_pend: got %b want 11111", {pend, irq}); else passed++;
    ack = 4'b1111; step(); ack = '0; #1;
    checks++; if ({pend, irq} !== 5'b00000) $display("FAIL rr_ack: got %b want 00000", {pend, irq}); else passed++;
  endtask

  task automatic test_one_shot();
    advance_to(8'd10);
    set_dly(1, 8'd5); req = 4'b0010; #1;
    checks++; if (now !== 8'd10) $display("FAIL os_now: got %0d want 10", now); else passed++;
    checks++; if (grant !== 4'b0010) $display("FAIL os_grant: got %b want 0010", grant); else passed++;
    step(); req = '0; #1;
    checks++; if (busy !== 4'b0010) $display("FAIL os_busy: got %b want 0010", busy); else passed++;
    repeat (4) step();
    checks++; if (expire !== 4'b0000) $display("FAIL os_early: got %b want 0000 at now=15", expire); else passed++;
    step();
    checks++; if (expire !== 4'b0010 || now !== 8'd16)
      $display("FAIL os_expire: got %b now=%0d want 0010 now=16", expire, now);
    else passed++;
    checks++; if ({busy, pend, irq} !== 9'b0000_0010_1)
      $display("FAIL os_state: got %b want 000000101", {busy, pend, irq});
    else passed++;
    step();
    checks++; if ({expire, irq} !== 5'b0000_1) $display("FAIL os_pulse: got %b want 00001", {expire, irq}); else passed++;
    ack = 4'b0010; step(); ack = '0; #1;
    checks++; if ({pend, irq} !== 5'b0) $display("FAIL os_ack: got %b want 00000", {pend, irq}); else passed++;
  endtask

  task automatic test_wrap();
    logic early;
    early = 1'b0;
    advance_to(8'd253);
    set_dly(0, 8'd10); req = 4'b0001; #1;
    checks++; if (grant !== 4'b0001) $display("FAIL wrap_grant: got %b want 0001", grant); else passed++;
    step(); req = '0;
    while (exp_now != 8'd8) begin
      early |= expire[0];
      step();
    end
    checks++; if (early !== 1'b0) $display("FAIL wrap_early: got %b want 0", early); else passed++;
    checks++; if (expire !== 4'b0001 || now !== 8'd8)
      $display("FAIL wrap_expire: got %b now=%0d want 0001 now=8", expire, now);
    else passed++;
    ack = 4'b0001; step(); ack = '0;
  endtask

  task automatic test_cancel_due();
    set_dly(2, 8'd3); req = 4'b0100; #1;
    checks++; if (grant !== 4'b0100) $display("FAIL cancel_grant: got %b want 0100", grant); else passed++;
    step(); req = '0;
    step(); step();
    cancel = 4'b0100; #1;
    checks++; if (grant !== 4'b0000) $display("FAIL cancel_nogrant: got %b want 0000", grant); else passed++;
    step(); cancel = '0; #1;
    checks++; if ({expire, busy, pend} !== 12'd0)
      $display("FAIL cancel_due: got %b want 0", {expire, busy, pend});
    else passed++;
    step();
    checks++; if (expire !== 4'b0000) $display("FAIL cancel_late: got %b want 0000", expire); else passed++;
  endtask

  task automatic test_ack_vs_expire();
    set_dly(0, 8'd2); req = 4'b0001; #1;
    checks++; if (grant !== 4'b0001) $display("FAIL ackexp_grant: got %b want 0001", grant); else passed++;
    step(); req = '0;
    step();
    ack = 4'b0001;
    step(); ack = '0; #1;
    checks++; if (expire !== 4'b0001 || pend !== 4'b0001)
      $display("FAIL ackexp_pend: got expire=%b pend=%b want 0001/0001", expire, pend);
    else passed++;
    ack = 4'b0001; step(); ack = '0; #1;
    checks++; if (pend !== 4'b0000) $display("FAIL ackexp_clear: got %b want 0000", pend); else passed++;
  endtask

  task automatic test_back_to_back();
    set_dly(3, 8'd2); req = 4'b1000; step(); req = '0;
    step();
    set_dly(3, 8'd4); req = 4'b1000; #1;
    checks++; if (grant !== 4'b1000) $display("FAIL b2b_grant: got %b want 1000", grant); else passed++;
    step(); req = '0; #1;
    checks++; if (expire !== 4'b0000 || busy !== 4'b1000)
      $display("FAIL b2b_nopulse: got expire=%b busy=%b want 0000/1000", expire, busy);
    else passed++;
    repeat (3) step();
    checks++; if (expire !== 4'b0000) $display("FAIL b2b_early: got %b want 0000", expire); else passed++;
    step();
    checks++; if (expire !== 4'b1000 || busy !== 4'b0000)
      $display("FAIL b2b_expire: got expire=%b busy=%b want 1000/0000", expire, busy);
    else passed++;
    ack = 4'b1000; step(); ack = '0;
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    set_dly(0, 8'd20); set_dly(2, 8'd20); req = 4'b0101;
    step(); step(); req = '0; #1;
    checks++; if (busy !== 4'b0101) $display("FAIL rmid_armed: got %b want 0101", busy); else passed++;
    repeat (3) step();
    #2 rst_n = 1'b0; exp_now = 8'd0; #1;
    checks++; if (now !== 8'd0) $display("FAIL rmid_now: got %0d want 0", now); else passed++;
    checks++; if ({busy, pend, expire, grant, irq} !== 17'd0)
      $display("FAIL rmid_outputs: got %b want 0", {busy, pend, expire, grant, irq});
    else passed++;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) begin
      bad |= (|expire) | (|busy);
      step();
    end
    checks++; if (bad !== 1'b0) $display("FAIL rmid_noexpire: got %b want 0", bad); else passed++;
    checks++; if (now !== 8'd30) $display("FAIL rmid_count: got %0d want 30", now); else passed++;
  endtask

`ifdef TIMER_SCHED_PERIODIC_EN
  task automatic test_periodic();
    logic [7:0] got [4];
    logic [7:0] want [4];
    int         n;
    logic       bad;
    want = '{8'd255, 8'd3, 8'd7, 8'd11};
    got  = '{default: 8'd0};
    n = 0; bad = 1'b0;
    periodic = 4'b1000;
    advance_to(8'd250);
    set_dly(3, 8'd4); req = 4'b1000; #1;
    checks++; if (grant !== 4'b1000) $display("FAIL per_grant: got %b want 1000", grant); else passed++;
    step(); req = '0;
    repeat (17) begin
      if (expire[3]) begin
        if (n < 4) got[n] = now;
        n++;
      end
      step();
    end
    checks++; if (n != 4) $display("FAIL per_count: got %0d want 4", n); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== want[i]) $display("FAIL per_time%0d: got %0d want %0d", i, got[i], want[i]); else passed++;
    end
    cancel = 4'b1000; step(); cancel = '0;
    repeat (10) begin
      bad |= expire[3] | busy[3];
      step();
    end
    checks++; if (bad !== 1'b0) $display("FAIL per_cancel: got %b want 0", bad); else passed++;
    periodic = '0;
  endtask
`endif

  initial begin
`ifdef TIMER_SCHED_PERIODIC_EN
    periodic = '0;
`endif
    test_reset();
    test_round_robin();
    test_one_shot();
    test_wrap();
    test_cancel_due();
    test_ack_vs_expire();
    test_back_to_back();
    test_reset_mid();
`ifdef TIMER_SCHED_PERIODIC_EN
    test_periodic();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
